// File: rtl/midi_msg_decoder.sv
// rtl/midi_msg_decoder.sv - MIDI channel-message decoder producing voice/controller update strobes
//
// Decodes a stream of received MIDI bytes into note and controller updates for
// one MIDI channel. Handles channel filtering, running status, real-time bytes
// interleaved anywhere, and SysEx skipping.
//
// Optional feature macro: MIDI_RUNNING_STATUS_EN
//   defined   - after a completed message the status is kept (running status)
//   undefined - after a completed message the decoder returns to IDLE
//
// Ports:
//   clk               in   system clock
//   reset             in   asynchronous active-low reset
//   byte_valid        in   byte_in carries a received byte this cycle (no back-pressure)
//   byte_in[7:0]      in   received MIDI byte
//   update_voice      out  one-cycle strobe, note_values is new
//   update_all_voices out  one-cycle strobe, controller_values is new
//   note_values[13:0] out  {note number, velocity}; velocity 0 means release
//   controller_values out  {controller number, controller value}
//   msg_error         out  one-cycle strobe on a data byte with no valid status
module midi_msg_decoder #(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        update_voice,
    output logic        update_all_voices,
    output logic [13:0] note_values,
    output logic [13:0] controller_values,
    output logic        msg_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SKIP    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  run_status_q, run_status_d;
    logic [6:0]  d1_q, d1_d;
    logic [13:0] note_q, note_d;
    logic [13:0] ctrl_q, ctrl_d;
    logic        uv_q, uv_d;
    logic        uav_q, uav_d;
    logic        err_q, err_d;

    logic is_realtime;
    logic is_channel_status;
    logic one_byte_msg;
    logic done;

    // 0xF8-0xFF may appear anywhere and must leave every register untouched.
    assign is_realtime       = (byte_in[7:3] == 5'b11111);
    assign is_channel_status = byte_in[7] && (byte_in[7:4] != 4'hF);
    // Program change (0xCn) and channel pressure (0xDn) carry a single data byte.
    assign one_byte_msg      = (run_status_q[7:5] == 3'b110);

    always_comb begin
        state_d      = state_q;
        run_status_d = run_status_q;
        d1_d         = d1_q;
        note_d       = note_q;
        ctrl_d       = ctrl_q;
        uv_d         = 1'b0;
        uav_d        = 1'b0;
        err_d        = 1'b0;
        done         = 1'b0;

        if (byte_valid && !is_realtime) begin
            if (byte_in[7]) begin
                // Any status byte abandons a partial message without comment.
                if (is_channel_status) begin
                    run_status_d = byte_in;
                    state_d      = WAIT_D1;
                end else if (byte_in == 8'hF0) begin
                    run_status_d = 8'h00;
                    state_d      = SKIP;
                end else begin
                    run_status_d = 8'h00;
                    state_d      = IDLE;
                end
            end else begin
                unique case (state_q)
                    IDLE: err_d = 1'b1;
                    WAIT_D1: begin
                        d1_d = byte_in[6:0];
                        if (one_byte_msg) begin
                            done = 1'b1;
                        end else begin
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: done = 1'b1;
                    default: ;  // SKIP: SysEx payload is dropped silently
                endcase
            end
        end

        if (done) begin
            // Other-channel and unsupported messages complete with no output.
            if (run_status_q[3:0] == CHANNEL) begin
                unique case (run_status_q[7:4])
                    4'h9: begin
                        note_d = {d1_q, byte_in[6:0]};
                        uv_d   = 1'b1;
                    end
                    4'h8: begin
                        note_d = {d1_q, 7'd0};
                        uv_d   = 1'b1;
                    end
                    4'hB: begin
                        ctrl_d = {d1_q, byte_in[6:0]};
                        uav_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
`ifdef MIDI_RUNNING_STATUS_EN
            state_d = WAIT_D1;
`else
            state_d      = IDLE;
            run_status_d = 8'h00;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            run_status_q <= 8'h00;
            d1_q         <= 7'd0;
            note_q       <= 14'd0;
            ctrl_q       <= 14'd0;
            uv_q         <= 1'b0;
            uav_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_status_q <= run_status_d;
            d1_q         <= d1_d;
            note_q       <= note_d;
            ctrl_q       <= ctrl_d;
            uv_q         <= uv_d;
            uav_q        <= uav_d;
            err_q        <= err_d;
        end
    end

    assign update_voice      = uv_q;
    assign update_all_voices = uav_q;
    assign note_values       = note_q;
    assign controller_values = ctrl_q;
    assign msg_error         = err_q;

endmodule

// File: tb/tb_midi_msg_decoder.sv
// tb/tb_midi_msg_decoder.sv - scoreboard bench for midi_msg_decoder with a message-level reference model
module tb_midi_msg_decoder;

    localparam logic [3:0] CH = 4'd0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        update_voice;
    logic        update_all_voices;
    logic [13:0] note_values;
    logic [13:0] controller_values;
    logic        msg_error;

    midi_msg_decoder #(.CHANNEL(CH)) dut (
        .clk               (clk),
        .reset             (reset),
        .byte_valid        (byte_valid),
        .byte_in           (byte_in),
        .update_voice      (update_voice),
        .update_all_voices (update_all_voices),
        .note_values       (note_values),
        .controller_values (controller_values),
        .msg_error         (msg_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = note update, 1 = controller update, 2 = error
    typedef struct {
        int          kind;
        logic [13:0] val;
        int          at;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state: current status (-1 none, -2 inside SysEx) and data collected so far.
    int         m_status = -1;
    logic [6:0] m_data[$];
    bit         running_status;

    function automatic int msg_len(input int st);
        int hi;
        hi = (st >> 4) & 15;
        return (hi == 12 || hi == 13) ? 1 : 2;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        int   hi;
        if (b >= 8'hF8) return;
        if (b[7]) begin
            m_data.delete();
            if (b < 8'hF0)       m_status = int'(b);
            else if (b == 8'hF0) m_status = -2;
            else                 m_status = -1;
            return;
        end
        if (m_status == -2) return;
        if (m_status == -1) begin
            e.kind = 2; e.val = 14'd0; e.at = cyc + 1;
            exp_q.push_back(e);
            return;
        end
        m_data.push_back(b[6:0]);
        if (m_data.size() == msg_len(m_status)) begin
            hi = (m_status >> 4) & 15;
            if ((m_status & 15) == int'(CH)) begin
                e.at = cyc + 1;
                if (hi == 9) begin
                    e.kind = 0; e.val = {m_data[0], m_data[1]}; exp_q.push_back(e);
                end else if (hi == 8) begin
                    e.kind = 0; e.val = {m_data[0], 7'd0}; exp_q.push_back(e);
                end else if (hi == 11) begin
                    e.kind = 1; e.val = {m_data[0], m_data[1]}; exp_q.push_back(e);
                end
            end
            m_data.delete();
            if (!running_status) m_status = -1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        byte_valid = 1'b1;
        byte_in    = b;
        model_byte(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            byte_valid = 1'b0;
            byte_in    = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        byte_valid = 1'b0;
        reset      = 1'b0;
        m_status   = -1;
        m_data.delete();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    function automatic logic [7:0] rand_byte();
        int r, k;
        logic [3:0] hi;
        r = $urandom_range(0, 99);
        if (r < 50) return 8'($urandom_range(0, 127));
        if (r < 80) begin
            k = $urandom_range(0, 8);
            case (k)
                0: hi = 4'h8;
                1, 2: hi = 4'h9;
                3, 4: hi = 4'hB;
                5: hi = 4'hA;
                6: hi = 4'hC;
                7: hi = 4'hD;
                default: hi = 4'hE;
            endcase
            return {hi, ($urandom_range(0, 3) == 0) ? 4'd1 : CH};
        end
        if (r < 88) return 8'hF8 + 8'($urandom_range(0, 7));
        if (r < 92) return 8'hF0;
        if (r < 95) return 8'hF7;
        return 8'hF0 + 8'($urandom_range(1, 6));
    endfunction

    // Monitor: compares every presented strobe against the scoreboard head and
    // checks the held output words every cycle.
    logic [13:0] exp_note = 14'd0;
    logic [13:0] exp_ctrl = 14'd0;
    bit final_req  = 1'b0;
    bit final_done = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (!reset) begin
            checks++;
            if ({update_voice, update_all_voices, msg_error} != 3'b000 ||
                note_values != 14'd0 || controller_values != 14'd0) begin
                errors++;
                $display("FAIL reset_outputs: got uv=%0b uav=%0b err=%0b note=%h ctrl=%h, want all 0",
                         update_voice, update_all_voices, msg_error, note_values, controller_values);
            end
            exp_note = 14'd0;
            exp_ctrl = 14'd0;
        end else begin
            if (32'(update_voice) + 32'(update_all_voices) + 32'(msg_error) > 1) begin
                checks++;
                errors++;
                $display("FAIL strobe_exclusive: uv=%0b uav=%0b err=%0b, want at most one",
                         update_voice, update_all_voices, msg_error);
            end
            if (update_voice || update_all_voices || msg_error) begin
                kind = update_voice ? 0 : (update_all_voices ? 1 : 2);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, want none", kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != kind || e.at != cyc) begin
                        errors++;
                        $display("FAIL strobe_kind_time: got kind %0d at cycle %0d, want kind %0d at cycle %0d",
                                 kind, cyc, e.kind, e.at);
                    end
                    if (e.kind == 0) exp_note = e.val;
                    if (e.kind == 1) exp_ctrl = e.val;
                end
            end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_strobe: got none at cycle %0d, want kind %0d val %h", cyc, e.kind, e.val);
                if (e.kind == 0) exp_note = e.val;
                if (e.kind == 1) exp_ctrl = e.val;
            end
            checks++;
            if (note_values != exp_note) begin
                errors++;
                $display("FAIL note_values: got %h, want %h (cycle %0d)", note_values, exp_note, cyc);
            end
            checks++;
            if (controller_values != exp_ctrl) begin
                errors++;
                $display("FAIL controller_values: got %h, want %h (cycle %0d)", controller_values, exp_ctrl, cyc);
            end
        end
        if (final_req && !final_done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain: got %0d outstanding, want 0", exp_q.size());
            end
            final_done = 1'b1;
        end
    end

    initial begin
`ifdef MIDI_RUNNING_STATUS_EN
        running_status = 1'b1;
`else
        running_status = 1'b0;
`endif
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(2);

        send(8'h90); send(8'h3C); send(8'h64);
        idle(3);
        send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h00);
        idle(3);
        send(8'hB0); send(8'hF8); send(8'h07); send(8'hFE); send(8'h7F);
        idle(3);
        send(8'h91); send(8'h3C); send(8'h64);
        send(8'h80); send(8'h3C); send(8'h10);
        idle(3);
        send(8'hF0); send(8'h7E); send(8'h01); send(8'h23); send(8'hF7);
        send(8'h90); send(8'h45); send(8'h50);
        idle(3);
        send(8'hF2); send(8'h11); send(8'h22);
        send(8'hC0); send(8'h05); send(8'h06);
        idle(3);
        send(8'h90); send(8'h3C);
        do_reset();
        send(8'h64);
        idle(3);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(rand_byte());
        end
        idle(4);

        final_req = 1'b1;
        for (int i = 0; i < 10 && !final_done; i++) @(posedge clk);
        idle(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
